// File: rtl/activity_watchdog_pkg.sv
// activity_watchdog_pkg
// Shared types and defaults for the multi-channel activity watchdog.
//   wdog_state_t       : per-channel FSM state (IDLE, COUNTING, EXPIRED)
//   *_DEF localparams  : default parameter widths and product target values
// The prescaler default is only used when ACTIVITY_WATCHDOG_PRESCALE_EN is defined.
package activity_watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    EXPIRED  = 2'd2
  } wdog_state_t;

  localparam int CHANNELS_DEF    = 4;
  localparam int WIDTH_DEF       = 26;
  localparam int GRACE_WIDTH_DEF = 22;
  localparam int PRESCALE_DEF    = 781;

  // Product targets at a 1.28 us clock: 4 s grace, 60 s inactivity timeout.
  localparam int GRACE_TARGET_DEF   = 3125000;
  localparam int TIMEOUT_TARGET_DEF = 46875000;

endpackage

// File: rtl/activity_watchdog_if.sv
// activity_watchdog_if
// Bundles the watchdog's configuration, per-channel inputs and status outputs.
//   grace_target, timeout_target : run-time targets in cycles (or ticks)
//   in, enable, clear, sticky    : per-channel idle level, enable, clear; global sticky mode
//   hit_target, expired_pulse    : per-channel status outputs
//   in_grace, any_hit            : global status outputs
// master drives the inputs (debouncer/config side), slave is the watchdog.
interface activity_watchdog_if
  import activity_watchdog_pkg::*;
#(
  parameter int CHANNELS    = CHANNELS_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int GRACE_WIDTH = GRACE_WIDTH_DEF
);

  logic [GRACE_WIDTH-1:0] grace_target;
  logic [WIDTH-1:0]       timeout_target;
  logic [CHANNELS-1:0]    in;
  logic [CHANNELS-1:0]    enable;
  logic                   sticky;
  logic [CHANNELS-1:0]    clear;
  logic [CHANNELS-1:0]    hit_target;
  logic [CHANNELS-1:0]    expired_pulse;
  logic                   in_grace;
  logic                   any_hit;

  modport master (
    output grace_target, timeout_target, in, enable, sticky, clear,
    input  hit_target, expired_pulse, in_grace, any_hit
  );

  modport slave (
    input  grace_target, timeout_target, in, enable, sticky, clear,
    output hit_target, expired_pulse, in_grace, any_hit
  );

endinterface

// File: rtl/wdog_channel.sv
// wdog_channel
// One inactivity-timeout channel: FSM, saturating counter, threshold compare
// and one-cycle expiry pulse.
//   clk, reset         : clock, asynchronous active-low reset
//   i_tick             : counter advance strobe (constant 1 without prescaler)
//   i_in               : idle level, high = idle (counting), low = activity
//   i_enable, i_clear  : channel enable, synchronous clear of expired state
//   i_sticky           : 1 = expiry latched until clear
//   i_timeout_target   : threshold in ticks, 0 = never newly expire
//   o_expired, o_pulse : state == EXPIRED, registered entry pulse
module wdog_channel
  import activity_watchdog_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_in,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_sticky,
  input  logic [WIDTH-1:0] i_timeout_target,
  output logic             o_expired,
  output logic             o_pulse
);

  wdog_state_t      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic             r_pulse;
  logic             w_thresh;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // One extra bit so a saturated counter still compares as "count+1".
  assign w_thresh = (i_timeout_target != '0) &&
                    (({1'b0, r_cnt} + (WIDTH+1)'(1)) >= {1'b0, i_timeout_target});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= (w_state_nxt == EXPIRED) && (r_state != EXPIRED);
    end
  end

  // Priority: disable, then clear / activity, then tick-gated counting.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!i_enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = COUNTING;
          w_cnt_nxt   = '0;
        end
        COUNTING: begin
          if (i_clear || !i_in) begin
            w_cnt_nxt = '0;
          end else if (i_tick) begin
            w_cnt_nxt = sat_inc(r_cnt);
            if (w_thresh) w_state_nxt = EXPIRED;
          end
        end
        EXPIRED: begin
          if (i_clear || (!i_sticky && !i_in)) begin
            w_state_nxt = COUNTING;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_expired = (r_state == EXPIRED);
  assign o_pulse   = r_pulse;

endmodule

// File: rtl/activity_watchdog.sv
// activity_watchdog
// Multi-channel inactivity watchdog with a shared start-up grace window.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : activity_watchdog_if.slave (targets, in/enable/clear/sticky,
//           hit_target, expired_pulse, in_grace, any_hit)
// Optional macro ACTIVITY_WATCHDOG_PRESCALE_EN adds parameter PRESCALE and a
// free-running divider; counters then advance once per PRESCALE cycles.
module activity_watchdog
  import activity_watchdog_pkg::*;
#(
  parameter int CHANNELS    = CHANNELS_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int GRACE_WIDTH = GRACE_WIDTH_DEF
`ifdef ACTIVITY_WATCHDOG_PRESCALE_EN
  ,
  parameter int PRESCALE    = PRESCALE_DEF
`endif
) (
  input  logic                clk,
  input  logic                reset,
  activity_watchdog_if.slave  bus
);

  logic                   w_tick;
  logic [GRACE_WIDTH-1:0] r_grace_cnt;
  logic                   w_in_grace;
  logic [CHANNELS-1:0]    w_expired;
  logic [CHANNELS-1:0]    w_pulse;
  logic [CHANNELS-1:0]    w_hit;

`ifdef ACTIVITY_WATCHDOG_PRESCALE_EN
  localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [DIV_W-1:0] r_div;

  assign w_tick = (r_div == DIV_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_div <= '0;
    else        r_div <= w_tick ? '0 : r_div + 1'b1;
  end
`else
  assign w_tick = 1'b1;
`endif

  // Saturates at grace_target; the compare against the live target makes
  // in_grace track grace_target!=0 while held in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grace_cnt <= '0;
    end else if (w_tick && (r_grace_cnt < bus.grace_target)) begin
      r_grace_cnt <= r_grace_cnt + 1'b1;
    end
  end

  assign w_in_grace = (r_grace_cnt < bus.grace_target);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    wdog_channel #(.WIDTH(WIDTH)) u_ch (
      .clk              (clk),
      .reset            (reset),
      .i_tick           (w_tick),
      .i_in             (bus.in[g]),
      .i_enable         (bus.enable[g]),
      .i_clear          (bus.clear[g]),
      .i_sticky         (bus.sticky),
      .i_timeout_target (bus.timeout_target),
      .o_expired        (w_expired[g]),
      .o_pulse          (w_pulse[g])
    );
  end

  assign w_hit             = {CHANNELS{w_in_grace}} | w_expired;
  assign bus.hit_target    = w_hit;
  assign bus.expired_pulse = w_pulse;
  assign bus.in_grace      = w_in_grace;
  assign bus.any_hit       = |w_hit;

endmodule

// File: doc/activity_watchdog.md
Name: activity_watchdog

Overview:
- Multi-channel successor to the fixed 4 s / 60 s special timer.
- A shared start-up grace window forces every channel's hit output high after reset.
- Each channel then runs its own inactivity timeout:
  - the counter runs while its input stays high;
  - any low cycle restarts it.
- Targets are run-time programmable. Each channel supports level or sticky expiry, with per-channel enable and clear. The block sits between the input debouncers and the alarm/LED logic.

Parameters:
CHANNELS, 4, number of independent watchdog channels
WIDTH, 26, width of per-channel timeout counter and timeout_target
GRACE_WIDTH, 22, width of global grace counter and grace_target

Ports:
clk  input  1  system clock (1.28 us period in the product build)
reset  input  1  asynchronous, active-low reset
grace_target  input  GRACE_WIDTH  grace window length in cycles; 0 = no grace window
timeout_target  input  WIDTH  inactivity timeout in cycles, shared by all channels; 0 = timeout disabled
in  input  CHANNELS  per-channel "idle" level; high = idle and counting, low = activity
enable  input  CHANNELS  per-channel enable
sticky  input  1  1 = expiry latches until clear; 0 = expiry drops on activity
clear  input  CHANNELS  per-channel synchronous clear of the expired state
hit_target  output  CHANNELS  in_grace OR channel expired
expired_pulse  output  CHANNELS  one-cycle pulse on entry to EXPIRED
in_grace  output  1  high while the grace window is running
any_hit  output  1  OR of hit_target

Behaviour:
- Reset (reset=0, asynchronous):
  - grace counter=0; all channel counters=0; all channel states=IDLE.
  - expired_pulse=0.
  - in_grace=1 if grace_target!=0, else 0. Therefore hit_target=all-ones when a grace window is programmed.
- Grace counter:
  - Increments every cycle after reset release and saturates at grace_target.
  - in_grace = (grace_count < grace_target), registered.
  - Example: with grace_target=G, in_grace falls exactly G edges after release.
- Channel FSM, states IDLE, COUNTING, EXPIRED:
  - Any state, enable[i]=0 -> IDLE; counter cleared.
  - IDLE with enable[i]=1 -> COUNTING; counter=0.
  - COUNTING:
    - in[i]=0 -> counter=0.
    - in[i]=1 -> counter+1, saturating.
    - When (counter+1 >= timeout_target) and timeout_target!=0 and in[i]=1: -> EXPIRED at that same edge, and expired_pulse[i]=1 for one cycle.
    - So with target T, hit_target rises on the T-th consecutive edge sampling in=1.
  - EXPIRED, sticky=0: in[i]=0 -> COUNTING, counter=0.
  - EXPIRED, sticky=1: stay until clear[i]=1 -> COUNTING, counter=0.
- Counters never wrap; they saturate at all-ones.
- hit_target[i] = in_grace | (state==EXPIRED). Outputs are registered or derived from registered state only; there is no combinational path from in[].
- Simultaneous events:
  - clear beats expiry in the same cycle: result is COUNTING, counter=0, no pulse.
  - enable=0 beats everything.
  - in=0 and expiry threshold in the same cycle: no expiry.
- Target change mid-operation: compare is >=, so lowering timeout_target below the current count expires on the next edge where in=1. Setting timeout_target=0 freezes channels in their current state; they never newly expire.
- Expiry during grace: the FSM still tracks state. hit_target is already high, but expired_pulse still fires.
- Reset asserted mid-operation returns everything to the reset values immediately.

Optional Feature:
- Macro ACTIVITY_WATCHDOG_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE (default 781).
  - An internal free-running divider produces a one-cycle tick every PRESCALE cycles.
  - The grace and channel counters advance only on tick cycles. in=0, clear and enable are still honoured every cycle.
  - Targets are then in ticks.
- Undefined: the tick is constantly 1 and counters advance every cycle, exactly as described above.

Decomposition:
- Package activity_watchdog_pkg holds:
  - typedef enum logic [1:0] {IDLE, COUNTING, EXPIRED} wdog_state_t;
  - default-width localparams;
  - default target constants for the product (3125000 grace, 46875000 timeout).
- Sub-module wdog_channel, one per channel via generate:
  - implements the FSM, counter, compare and pulse;
  - inputs: clk, reset, tick, in, enable, clear, sticky, timeout_target;
  - top level keeps the grace counter, prescaler and output ORs.

Test Plan:
- Reset with grace_target=15 and all in=1, enable=all: hit_target=4'b1111 and in_grace=1 for 15 edges, then in_grace=0 and hit_target=0 (timeout_target=40 not yet reached).
- grace_target=0, timeout_target=10, in[0] held 1: hit_target[0] rises on the 10th edge, expired_pulse[0] is high exactly one cycle, other channels unaffected.
- sticky=0, channel 1 expired, in[1]=0 for one cycle: hit_target[1] falls the next edge, and re-expires 10 edges after in[1] returns high.
- sticky=1, channel 2 expired, in[2] toggled low: hit_target[2] stays 1; clear[2] pulse drops it; clear and threshold in the same cycle produce no expiry.
- Counter at 30 with timeout_target=40, timeout_target changed to 20: expiry on the next edge. timeout_target=0: no channel ever expires over 200 cycles.
- Reset dropped mid-count while a channel is EXPIRED: all outputs return to reset values asynchronously, before the next clk edge.
